// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial adder: slice width, FSM states and
// the byte-index width helper.
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that walks bytes 0..nbytes-1 (never zero bits wide)
  function automatic int idx_width(input int nbytes);
    return (nbytes > 32'sd1) ? $clog2(nbytes) : 32'sd1;
  endfunction

endpackage

// File: rtl/add8.sv
// Combinational 8-bit adder slice, reused once per byte by add_seq.
module add8
  import add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  // Ripple sum of one byte with carry in and carry out
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/add_seq.sv
// Byte-serial A+B+CIN adder: one add8 slice walked LSB byte first over NBYTES cycles.
// Optional macro ADD_SEQ_SUB_EN adds a SUB port selecting A+~B+1.
module add_seq
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] A,
  input  logic [BYTE_W*NBYTES-1:0] B,
  input  logic                     CIN,
`ifdef ADD_SEQ_SUB_EN
  input  logic                     SUB,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES:0]   SUM,
  output logic                     busy
);

  localparam int DW    = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DW-1:0]     a_r;
  logic [DW-1:0]     b_r;
  logic              sub_r;
  logic              carry_r;
  logic [DW:0]       sum_r;
  logic              out_valid_r;
  logic              in_ready_r;
  logic              busy_r;

  logic              sub_s;
  logic [BYTE_W-1:0] slice_a_s;
  logic [BYTE_W-1:0] slice_b_s;
  logic [BYTE_W-1:0] slice_sum_s;
  logic              slice_cout_s;

`ifdef ADD_SEQ_SUB_EN
  assign sub_s = SUB;
`else
  assign sub_s = 1'b0;
`endif

  // Select byte idx_r of the latched operands; subtraction feeds the inverted B byte
  always_comb begin
    slice_a_s = {BYTE_W{1'b0}};
    slice_b_s = {BYTE_W{1'b0}};
    for (int i = 0; i < NBYTES; i++) begin
      slice_a_s = slice_a_s | (a_r[i*BYTE_W +: BYTE_W] & {BYTE_W{idx_r == IDX_W'(i)}});
      slice_b_s = slice_b_s | (b_r[i*BYTE_W +: BYTE_W] & {BYTE_W{idx_r == IDX_W'(i)}});
    end
    slice_b_s = sub_r ? ~slice_b_s : slice_b_s;
  end

  add8 u_add8 (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Control FSM with operand latches, carry/sum accumulation and registered handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= A;
            b_r        <= B;
            sub_r      <= sub_s;
            // Subtraction supplies the +1 of the two's complement through the carry
            carry_r    <= sub_s ? 1'b1 : CIN;
            idx_r      <= '0;
            sum_r      <= '0;
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_r == IDX_W'(i)) begin
              sum_r[i*BYTE_W +: BYTE_W] <= slice_sum_s;
            end
          end
          carry_r <= slice_cout_s;
          if (idx_r == LAST_IDX) begin
            sum_r[DW]   <= slice_cout_s;
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          carry_r     <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign SUM       = sum_r;

endmodule

// File: tb/tb_add_seq.sv
// Directed, table-driven bench for add_seq (NBYTES=4) with hand-written handshake and reset sequences.
module tb_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   A;
  logic [31:0]   B;
  logic          CIN;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  SUM;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]  a;
    logic [31:0]  b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    string        name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
`ifdef ADD_SEQ_SUB_EN
    .SUB       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (SUM),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic s, input logic [W-1:0] exp, input string name);
    vec_t v;
    v.a = a; v.b = b; v.cin = c; v.sub = s; v.sum = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Step until out_valid, bounded; returns edges counted after the accept edge
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input logic [W-1:0] exp, input string tag);
    int lat;
    check({tag, " in_ready before"}, in_ready, 1'b1);
    in_valid = 1'b1; A = a; B = b; CIN = c; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = $urandom; CIN = ~c; sub = ~s;
    check({tag, " busy"}, busy, 1'b1);
    wait_valid(lat);
    check({tag, " latency"}, W'(lat), W'(NB));
    check({tag, " sum"}, SUM, exp);
    check({tag, " in_ready in DONE"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid cleared"}, out_valid, 1'b0);
    check({tag, " sum held"}, SUM, exp);
  endtask

  initial begin
    int lat;
    int n;
    int accepts;
    int t[2];
    logic [W-1:0] s[2];
    logic prev_busy;
    logic saw_valid;

    add_vec(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 33'h0_00000100, "ff_plus_1");
    add_vec(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 33'h1_00000000, "carry_chain");
    add_vec(32'h12345678, 32'h11111111, 1'b0, 1'b0, 33'h0_23456789, "no_carry");
    add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 33'h1_FFFFFFFF, "all_ones");
    add_vec(32'h00000000, 32'h00000000, 1'b0, 1'b0, 33'h0_00000000, "zeros");
    add_vec(32'h80000000, 32'h80000000, 1'b0, 1'b0, 33'h1_00000000, "msb_carry");
    add_vec(32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 33'h0_01000100, "mid_carries");
    add_vec(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 33'h0_DFD10456, "mixed");
`ifdef ADD_SEQ_SUB_EN
    add_vec(32'h00000005, 32'h00000003, 1'b0, 1'b1, 33'h1_00000002, "sub_5_3");
    add_vec(32'h00000003, 32'h00000005, 1'b1, 1'b1, 33'h0_FFFFFFFE, "sub_3_5");
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; CIN = 1'b0; sub = 1'b0;
    #1;
    check("reset sum", SUM, '0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready after reset", in_ready, 1'b1);

    // out_ready with nothing pending does nothing
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle out_ready busy", busy, 1'b0);
    check("idle out_ready out_valid", out_valid, 1'b0);
    check("idle out_ready in_ready", in_ready, 1'b1);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sum, vecs[i].name);
    end

    // Result held while consumer stalls; new requests ignored
    in_valid = 1'b1; A = 32'h0000FFFF; B = 32'h00000001; CIN = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("stall latency", W'(lat), W'(NB));
    in_valid = 1'b1; A = 32'hAAAAAAAA; B = 32'h55555555; CIN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall sum", SUM, 33'h0_00010000);
      check("stall in_ready", in_ready, 1'b0);
      check("stall out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall release sum", SUM, 33'h0_00010000);
    check("stall release busy", busy, 1'b0);

    // Reset after byte 2 of RUN abandons the operation
    in_valid = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; CIN = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("midrun reset sum", SUM, '0);
    check("midrun reset out_valid", out_valid, 1'b0);
    check("midrun reset busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | out_valid;
    end
    check("no valid after reset", saw_valid, 1'b0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 33'h0_23456789, "after_reset");

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    in_valid = 1'b1; A = 32'h00000001; B = 32'h00000002; CIN = 1'b0; sub = 1'b0;
    n = 0; accepts = 0; prev_busy = 1'b0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        accepts++;
        if (accepts == 1) begin
          A = 32'hFFFF0000; B = 32'h00010000;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        t[n] = i; s[n] = SUM; n++;
      end
      prev_busy = busy;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b result count", W'(n), W'(2));
    if (n == 2) begin
      check("b2b first sum", s[0], 33'h0_00000003);
      check("b2b second sum", s[1], 33'h1_00000000);
      check("b2b spacing", W'(t[1] - t[0]), W'(NB + 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
